// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle computer observation path.
package multicycle_pkg;

    // Controller encoding of the instruction fetch state.
    localparam logic [3:0] FETCH_STATE_ENC = 4'd0;

    // Snapshot layout: {seq[7:0], FLAGS[3:0], R1[7:0], R0[7:0]}.
    localparam int SNAP_W = 28;

    typedef enum logic {
        ARMING  = 1'b0,
        RUNNING = 1'b1
    } mon_state_e;

endpackage

// File: rtl/retire_fifo.sv
// DEPTH x WIDTH synchronous FIFO with first-word-fall-through read data.
module retire_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 28
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, wptr_d;
    logic [AW-1:0]       rptr_q, rptr_d;
    logic [AW:0]         count_q, count_d;
    logic                do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH[AW:0]);
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/multicycle_retire_monitor.sv
// Captures an architectural snapshot each time the computer retires an
// instruction (re-enters fetch) and queues it for a valid/ready consumer.
module multicycle_retire_monitor
    import multicycle_pkg::*;
#(
    parameter int         DEPTH       = 16,
    parameter logic [3:0] FETCH_STATE = FETCH_STATE_ENC
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               state,
    input  logic [7:0]               R0_in,
    input  logic [7:0]               R1_in,
    input  logic [3:0]               FLAGS_in,
    input  logic                     enable,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [SNAP_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               dropped
);

    mon_state_e          fsm_q, fsm_d;
    logic [3:0]          prev_state_q;
    logic [7:0]          seq_q, seq_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          dropped_q, dropped_d;

    logic                retire, push, pop, drop;
    logic                fifo_full, fifo_empty;
    logic [SNAP_W-1:0]   snapshot;

    assign retire   = (prev_state_q != FETCH_STATE) && (state == FETCH_STATE);
    assign push     = retire && (fsm_q == RUNNING) && enable;
    assign pop      = rd_valid && rd_ready;
    assign drop     = push && fifo_full && !pop;
    assign snapshot = {seq_q, FLAGS_in, R1_in, R0_in};

    assign rd_valid = !fifo_empty;
    assign overflow = overflow_q;
    assign dropped  = dropped_q;

    // Arming waits out the fetch right after reset; retirement accounting.
    always_comb begin
        fsm_d      = fsm_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        case (fsm_q)
            ARMING:  if (state != FETCH_STATE) fsm_d = RUNNING;
            RUNNING: if (retire) seq_d = seq_q + 8'd1;
            default: fsm_d = ARMING;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
            if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
        end
    end

    // Monitor state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q        <= ARMING;
            prev_state_q <= FETCH_STATE;
            seq_q        <= 8'd0;
            overflow_q   <= 1'b0;
            dropped_q    <= 8'd0;
        end else begin
            fsm_q        <= fsm_d;
            prev_state_q <= state;
            seq_q        <= seq_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
        end
    end

    retire_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SNAP_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (snapshot),
        .rdata (rd_data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_multicycle_retire_monitor.sv
// Scoreboard bench: a queue-based model of the retire monitor predicts the
// snapshot stream; a negedge monitor compares the DUT against it.
module tb_multicycle_retire_monitor;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  state = 4'd0;
    logic [7:0]  R0_in = 8'd0;
    logic [7:0]  R1_in = 8'd0;
    logic [3:0]  FLAGS_in = 4'd0;
    logic        enable = 1'b1;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [27:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  dropped;

    int tests = 0;
    int fails = 0;

    multicycle_retire_monitor #(.DEPTH(DEPTH), .FETCH_STATE(4'd0)) dut (
        .clock    (clock),
        .reset    (reset),
        .state    (state),
        .R0_in    (R0_in),
        .R1_in    (R1_in),
        .FLAGS_in (FLAGS_in),
        .enable   (enable),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow),
        .dropped  (dropped)
    );

    always #5 clock = ~clock;

    // Reference model: queue of expected snapshots plus drop bookkeeping.
    logic [27:0] exp_q[$];
    bit          m_seen_busy = 0;
    logic [3:0]  m_prev = 4'd0;
    logic [7:0]  m_seq = 8'd0;
    bit          m_overflow = 0;
    int          m_dropped = 0;
    bit          m_started = 0;

    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            m_seen_busy = 0;
            m_prev      = 4'd0;
            m_seq       = 8'd0;
            m_overflow  = 0;
            m_dropped   = 0;
            m_started   = 1;
        end else begin
            bit did_pop;
            bit retired;
            did_pop = rd_ready && (exp_q.size() > 0);
            retired = m_seen_busy && (m_prev != 4'd0) && (state == 4'd0);
            if (did_pop) void'(exp_q.pop_front());
            if (retired) begin
                if (enable) begin
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back({m_seq, FLAGS_in, R1_in, R0_in});
                    end else begin
                        m_overflow = 1;
                        if (m_dropped < 255) m_dropped++;
                    end
                end
                m_seq = m_seq + 8'd1;
            end
            if (state != 4'd0) m_seen_busy = 1;
            m_prev = state;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every observable output with the model each cycle.
    always @(negedge clock) begin
        if (m_started && !reset) begin
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_q.size() > 0});
            chk("count", {27'd0, count}, exp_q.size());
            chk("overflow", {31'd0, overflow}, {31'd0, m_overflow});
            chk("dropped", {24'd0, dropped}, m_dropped);
            if (rd_valid && exp_q.size() > 0)
                chk("rd_data", {4'd0, rd_data}, {4'd0, exp_q[0]});
        end
    end

    task automatic tick(input logic [3:0] st);
        state = st;
        @(negedge clock);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        state = 4'd0;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic retire_op(input logic [7:0] r0, input logic [7:0] r1, input logic [3:0] fl);
        tick(4'd1);
        tick(4'd2);
        R0_in = r0;
        R1_in = r1;
        FLAGS_in = fl;
        tick(4'd0);
    endtask

    initial begin
        @(negedge clock);
        // Reset, then sit in fetch: nothing captured.
        do_reset(2);
        repeat (3) tick(4'd0);
        chk("idle_count", {27'd0, count}, 32'd0);
        chk("idle_valid", {31'd0, rd_valid}, 32'd0);
        retire_op(8'hA5, 8'h3C, 4'h9);
        chk("first_valid", {31'd0, rd_valid}, 32'd1);
        chk("first_data", {4'd0, rd_data}, {4'd0, 8'h00, 4'h9, 8'h3C, 8'hA5});
        rd_ready = 1'b1;
        repeat (2) tick(4'd0);
        rd_ready = 1'b0;

        // Three retirements drained in order.
        do_reset(2);
        retire_op(8'h05, 8'h11, 4'h1);
        retire_op(8'h0A, 8'h22, 4'h2);
        retire_op(8'h0F, 8'h33, 4'h3);
        chk("three_count", {27'd0, count}, 32'd3);
        rd_ready = 1'b1;
        repeat (3) tick(4'd0);
        chk("drained_valid", {31'd0, rd_valid}, 32'd0);
        rd_ready = 1'b0;

        // Enable gating: seq still advances on ignored retirements.
        do_reset(2);
        enable = 1'b0;
        retire_op(8'h01, 8'h01, 4'h1);
        retire_op(8'h02, 8'h02, 4'h2);
        enable = 1'b1;
        retire_op(8'h03, 8'h03, 4'h3);
        chk("enable_count", {27'd0, count}, 32'd1);
        chk("enable_seq", {24'd0, rd_data[27:20]}, 32'd2);

        // Overflow: 18 retirements into 16 entries.
        do_reset(2);
        for (int i = 0; i < 18; i++) retire_op(8'(i), 8'(i * 3), 4'(i));
        chk("full_count", {27'd0, count}, 32'd16);
        chk("full_overflow", {31'd0, overflow}, 32'd1);
        chk("full_dropped", {24'd0, dropped}, 32'd2);
        rd_ready = 1'b1;
        tick(4'd0);
        rd_ready = 1'b0;
        retire_op(8'h77, 8'h88, 4'h5);
        chk("refill_count", {27'd0, count}, 32'd16);
        // Full with a pop on the retire edge: accepted, nothing dropped.
        tick(4'd1);
        tick(4'd2);
        rd_ready = 1'b1;
        tick(4'd0);
        rd_ready = 1'b0;
        chk("full_pop_count", {27'd0, count}, 32'd16);
        chk("full_pop_dropped", {24'd0, dropped}, 32'd2);

        // Reset mid-operation discards everything and restarts seq.
        do_reset(1);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_dropped", {24'd0, dropped}, 32'd0);
        retire_op(8'h42, 8'h24, 4'hC);
        chk("rst_seq", {24'd0, rd_data[27:20]}, 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                R0_in    = 8'($urandom);
                R1_in    = 8'($urandom);
                FLAGS_in = 4'($urandom);
                enable   = ($urandom_range(0, 7) != 0);
                rd_ready = ($urandom_range(0, 3) == 0);
                tick(($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 5)));
            end
        end
        rd_ready = 1'b1;
        repeat (20) tick(4'd0);
        chk("final_empty", {31'd0, rd_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_retire_monitor.md
Name: multicycle_retire_monitor

Overview:
Observer block that sits beside multicycle_computer_all and watches its state, R0_out, R1_out and FLAGS outputs. On every instruction retirement (the controller re-entering the fetch state), it captures a snapshot of architectural state. Snapshots go into a small FIFO that a bench or debug port drains with a valid/ready handshake. It is the consuming end of the computer's observation interface, synthesizable so it can also ship on the board.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
FETCH_STATE, 4'd0, state encoding of the fetch state

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
state  input  4  controller state from computer
R0_in  input  8  R0_out from computer
R1_in  input  8  R1_out from computer
FLAGS_in  input  4  FLAGS from computer
enable  input  1  capture enable; retirements still counted when low
rd_ready  input  1  consumer accepts head entry
rd_valid  output  1  FIFO non-empty
rd_data  output  28  head snapshot {seq[7:0], FLAGS[3:0], R1[7:0], R0[7:0]}
count  output  $clog2(DEPTH)+1  entries held
overflow  output  1  sticky: a snapshot was dropped
dropped  output  8  dropped-snapshot count, saturates at 255

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clock and reset.
- Reset values: rd_valid=0, count=0, overflow=0, dropped=0, seq=0, prev_state=FETCH_STATE, FSM=ARMING. rd_data is don't-care while rd_valid=0.
- Retire event: prev_state != FETCH_STATE && state == FETCH_STATE, sampled on the same edge. prev_state is a register of state.
- FSM:
  - ARMING: ignores retire events. Goes to RUNNING on the first cycle where state != FETCH_STATE, which skips the initial fetch after reset.
  - RUNNING: processes retire events.
  - No other states. reset from any state returns to ARMING.
- seq: 8-bit retirement counter, increments on every retire event in RUNNING regardless of enable. Wraps 255->0.
- Snapshot value: uses the pre-increment seq. The first retirement is therefore seq=0.
- Push: retire && RUNNING && enable. Snapshot = {seq, FLAGS_in, R1_in, R0_in} sampled that cycle, written next edge.
- Pop: rd_valid && rd_ready. Head advances next edge.
- rd_data is first-word-fall-through: it shows the head entry combinationally from storage while rd_valid=1.
- Full (count==DEPTH):
  - Push with simultaneous pop: accepted, count unchanged.
  - Push without pop: dropped. overflow<=1 and dropped increments, saturating at 255.
- Empty: rd_ready is ignored, no pointer movement. Push into empty sets rd_valid=1 on the next cycle, so there is no same-cycle bypass.
- Simultaneous push and pop when not full/empty: both take effect, count unchanged.
- Pointers: log2(DEPTH) bits, wrap naturally.
- overflow and dropped clear only on reset.
- Reset mid-operation: all entries are discarded and the next capture starts at seq=0.

Decomposition:
- Shared package multicycle_pkg:
  - FETCH_STATE encoding
  - snapshot width constant (28)
  - monitor FSM encoding (ARMING, RUNNING)
- Sub-module retire_fifo: parameterized DEPTH x 28 synchronous FIFO with count/full/empty. The top holds edge detection, the FSM, seq and the drop accounting.

Test Plan:
- Reset held 2 cycles, then state stays 0 -> rd_valid=0, count=0, no capture. Drive state 1,2,0 -> ARMING ends at state 1; one entry with seq=0 and current R0/R1/FLAGS.
- Three retirements with R0=8'h05/8'h0A/8'h0F, rd_ready=0, then rd_ready=1 -> three entries in order with seq 0,1,2 and matching R0; rd_valid drops after the third pop.
- DEPTH=16, 18 retirements with rd_ready=0 -> count=16, overflow=1, dropped=2. Entries hold seq 0..15; the next retirement yields seq=18 after one pop.
- FIFO full with rd_ready=1 on a retirement cycle -> count stays 16, no drop, tail gets the new seq.
- enable=0 for 2 retirements, then enable=1 for 1 -> single entry with seq=2.
- Reset asserted with 5 entries queued -> next cycle count=0, rd_valid=0, overflow=0. The following retirement after re-arming produces seq=0.
